// File: rtl/otp_prog_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : otp_prog_ctrl_if
//  Purpose  : Host-side request/response bundle for otp_prog_ctrl.
//             The host (master) issues single-cycle program/read requests
//             and lock pulses; the controller (slave) returns busy, ack,
//             read data and the error flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface otp_prog_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req;
  logic              op;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              lock_req;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, op, host_addr, host_wdata, lock_req,
    input  busy, ack, rdata, err
  );

  modport slave (
    input  req, op, host_addr, host_wdata, lock_req,
    output busy, ack, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/otp_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : otp_prog_ctrl
//  Purpose  : Sequencer between the host and a 128x8 OTP array. Converts a
//             single-cycle host request into the array strobe protocol
//             (cs_en, addr, din, pclk program pulse, rclk read level),
//             captures read data, and owns the sticky write-protect lock.
//  Options  : OTP_VERIFY_EN - when defined, every program operation is
//             followed by a read-back; err reports a data mismatch as well
//             as a locked program.
//  Revision : 1.0 - initial release
// ============================================================================
module otp_prog_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int PROG_CYC  = 8,
  parameter int RD_CYC    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  otp_prog_ctrl_if.slave    host,
  output logic              otp_cs_en,
  output logic              otp_pclk,
  output logic              otp_rclk,
  output logic [ADDR_W-1:0] otp_addr,
  output logic [DATA_W-1:0] otp_din,
  output logic              otp_wrong,
  input  logic [DATA_W-1:0] otp_dout
);

`ifdef OTP_VERIFY_EN
  localparam logic VERIFY_EN = 1'b1;
`else
  localparam logic VERIFY_EN = 1'b0;
`endif

  // One shared dwell counter sized for the longest timed state.
  localparam int MAX_CYC = (SETUP_CYC > PROG_CYC)
                         ? ((SETUP_CYC > RD_CYC) ? SETUP_CYC : RD_CYC)
                         : ((PROG_CYC  > RD_CYC) ? PROG_CYC  : RD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_PROG     = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_RD_SETUP = 3'd4;
  localparam logic [2:0] S_RD       = 3'd5;
  localparam logic [2:0] S_CAPT     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              op_q,     op_d;
  logic              locked_q, locked_d;
  logic              lock_q,   lock_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] din_q,    din_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              busy_q,   busy_d;
  logic              ack_q,    ack_d;
  logic              err_q,    err_d;
  logic              cs_en_q,  cs_en_d;
  logic              pclk_q,   pclk_d;
  logic              rclk_q,   rclk_d;

  // Counter reload value on entry: a state lasting N cycles loads N-1.
  function automatic logic [CNT_W-1:0] dwell(input logic [2:0] st);
    case (st)
      S_SETUP: dwell = CNT_W'(SETUP_CYC - 1);
      S_PROG:  dwell = CNT_W'(PROG_CYC - 1);
      S_RD:    dwell = CNT_W'(RD_CYC - 1);
      default: dwell = '0;
    endcase
  endfunction

  // Next-state, operation latches, lock and read capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    locked_d = locked_q;
    lock_d   = lock_q | host.lock_req;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (host.req) begin
          state_d  = host.op ? S_RD_SETUP : S_SETUP;
          op_d     = host.op;
          // A lock pulse on the accept edge already protects this request.
          locked_d = lock_q | host.lock_req;
          addr_d   = host.host_addr;
          din_d    = host.op ? '0 : host.host_wdata;
        end
      end
      S_SETUP:    if (cnt_q == '0) state_d = S_PROG;
      S_PROG:     if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD:     state_d = VERIFY_EN ? S_RD_SETUP : S_DONE;
      S_RD_SETUP: state_d = S_RD;
      S_RD: begin
        if (cnt_q == '0) begin
          state_d = S_CAPT;
          rdata_d = otp_dout;
        end
      end
      S_CAPT:     state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
        din_d   = '0;
      end
      default:    state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = dwell(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Output flops are decoded from the next state so they align with it.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    ack_d   = (state_d == S_DONE);
    cs_en_d = (state_d != S_IDLE) && (state_d != S_DONE);
    pclk_d  = (state_d == S_PROG) && !locked_d;
    rclk_d  = (state_d == S_RD);
    // rdata_q already holds the read-back value when CAPT hands over to DONE.
    err_d   = ack_d && !op_d &&
              (locked_d || (VERIFY_EN && (rdata_q != din_q)));
  end

  // State and output registers; reset aborts any strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      locked_q <= 1'b0;
      lock_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cs_en_q  <= 1'b0;
      pclk_q   <= 1'b0;
      rclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      locked_q <= locked_d;
      lock_q   <= lock_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cs_en_q  <= cs_en_d;
      pclk_q   <= pclk_d;
      rclk_q   <= rclk_d;
    end
  end

  assign host.busy  = busy_q;
  assign host.ack   = ack_q;
  assign host.rdata = rdata_q;
  assign host.err   = err_q;
  assign otp_cs_en  = cs_en_q;
  assign otp_pclk   = pclk_q;
  assign otp_rclk   = rclk_q;
  assign otp_addr   = addr_q;
  assign otp_din    = din_q;
  assign otp_wrong  = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_otp_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otp_prog_ctrl
//  Purpose  : Self-checking bench for otp_prog_ctrl with a behavioural OTP
//             array and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otp_prog_ctrl;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int S  = 2;
  localparam int P  = 8;
  localparam int R  = 2;
`ifdef OTP_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int LEN_RD = R + 3;
  localparam int LEN_PG = VER ? (S + P + R + 4) : (S + P + 2);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          otp_cs_en, otp_pclk, otp_rclk, otp_wrong;
  logic [AW-1:0] otp_addr;
  logic [DW-1:0] otp_din, otp_dout;

  otp_prog_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

  otp_prog_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S), .PROG_CYC(P), .RD_CYC(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (hif),
    .otp_cs_en (otp_cs_en),
    .otp_pclk  (otp_pclk),
    .otp_rclk  (otp_rclk),
    .otp_addr  (otp_addr),
    .otp_din   (otp_din),
    .otp_wrong (otp_wrong),
    .otp_dout  (otp_dout)
  );

  always #5 clk = ~clk;

  // Behavioural array: writes on pclk rise unless locked, FF when locked.
  logic [DW-1:0] arr [0:127] = '{default: 8'h00};
  bit            force_en  = 1'b0;
  logic [DW-1:0] force_val = 8'h00;
  always @(posedge otp_pclk) if (otp_cs_en && !otp_wrong) arr[otp_addr] <= otp_din;
  assign otp_dout = !otp_rclk ? 8'h00 :
                    (otp_wrong ? 8'hFF : (force_en ? force_val : arr[otp_addr]));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one transaction of m_len cycles, cycle index m_k.
  bit            m_act = 1'b0, m_op = 1'b0, m_locked = 1'b0, m_lock = 1'b0;
  int            m_k = 0, m_len = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rdata = '0;
  logic [DW-1:0] ref_mem [0:127] = '{default: 8'h00};

  function automatic int capt_idx(input bit op);
    return op ? (R + 2) : (VER ? (S + P + R + 3) : -1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act   <= 1'b0;
      m_lock  <= 1'b0;
      m_rdata <= '0;
      m_k     <= 0;
    end else begin
      if (hif.lock_req) m_lock <= 1'b1;
      if (m_act) begin
        m_k <= m_k + 1;
        if (m_k + 1 > m_len) m_act <= 1'b0;
        if (m_k + 1 == capt_idx(m_op))
          m_rdata <= m_locked ? 8'hFF : (force_en ? force_val : ref_mem[m_addr]);
      end else if (hif.req) begin
        m_act    <= 1'b1;
        m_k      <= 1;
        m_op     <= hif.op;
        m_addr   <= hif.host_addr;
        m_wd     <= hif.host_wdata;
        m_locked <= m_lock | hif.lock_req;
        m_len    <= hif.op ? LEN_RD : LEN_PG;
        if (!hif.op && !(m_lock | hif.lock_req)) ref_mem[hif.host_addr] <= hif.host_wdata;
      end
    end
  end

  // Cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",  32'(hif.busy),  32'(m_act));
      chk("ack",   32'(hif.ack),   32'(m_act && m_k == m_len));
      chk("cs_en", 32'(otp_cs_en), 32'(m_act && m_k < m_len));
      chk("addr",  32'(otp_addr),  32'(m_act ? m_addr : 7'h00));
      chk("din",   32'(otp_din),   32'((m_act && !m_op) ? m_wd : 8'h00));
      chk("pclk",  32'(otp_pclk),  32'(m_act && !m_op && !m_locked && m_k >= S + 1 && m_k <= S + P));
      chk("rclk",  32'(otp_rclk),  32'(m_act && (m_op ? (m_k >= 2 && m_k <= R + 1)
                                       : (VER && m_k >= S + P + 3 && m_k <= S + P + R + 2))));
      chk("wrong", 32'(otp_wrong), 32'(m_lock));
      chk("rdata", 32'(hif.rdata), 32'(m_rdata));
      if (m_act && m_k == m_len)
        chk("err", 32'(hif.err), 32'(!m_op && (m_locked || (VER && m_rdata != m_wd))));
    end
  end

  // One host transaction from an IDLE cycle; noise 1 = req every cycle, 2 = random req.
  task automatic run_op(input bit op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit lk, input int noise,
                        output int ac, output logic er, output logic [DW-1:0] rd,
                        output int pf, output int pl);
    ac = -1; er = 1'b0; rd = '0; pf = -1; pl = -1;
    hif.req = 1'b1; hif.op = op; hif.host_addr = a; hif.host_wdata = d; hif.lock_req = lk;
    @(posedge clk); #1;
    hif.req = 1'b0; hif.lock_req = 1'b0;
    for (int c = 1; c <= 100 && ac < 0; c++) begin
      @(negedge clk);
      if (otp_pclk) begin
        if (pf < 0) pf = c;
        pl = c;
      end
      if (hif.ack) begin
        ac = c; er = hif.err; rd = hif.rdata;
      end
      #1;
      hif.req = (noise == 1) ? 1'b1 : ((noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      hif.op = 1'($urandom_range(0, 1));
      hif.host_addr = 7'($urandom);
      hif.host_wdata = 8'($urandom);
    end
    if (ac < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
    end
    @(negedge clk); #1;
    hif.req = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  int            ac, pf, pl;
  logic          e;
  logic [DW-1:0] rd;

  initial begin
    hif.req = 1'b0; hif.op = 1'b0; hif.host_addr = '0; hif.host_wdata = '0; hif.lock_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({hif.busy, hif.ack, hif.err, hif.rdata, otp_cs_en, otp_pclk,
                              otp_rclk, otp_addr, otp_din, otp_wrong}), 32'h0);
    #3 rst_n = 1'b1;
    @(negedge clk); #1;

    // Program 05/A5 then read it back.
    run_op(1'b0, 7'h05, 8'hA5, 1'b0, 0, ac, e, rd, pf, pl);
    chk("prog_ack_cycle", ac, VER ? 16 : 12);
    chk("prog_pclk_first", pf, 3);
    chk("prog_pclk_last", pl, 10);
    chk("prog_err", 32'(e), 0);
    run_op(1'b1, 7'h05, 8'h00, 1'b0, 0, ac, e, rd, pf, pl);
    chk("read_ack_cycle", ac, 5);
    chk("read_rdata", 32'(rd), 32'hA5);
    chk("read_err", 32'(e), 0);

    // Array forced to return 38 on reads while programming 7F/3C.
    force_en = 1'b1; force_val = 8'h38;
    run_op(1'b0, 7'h7F, 8'h3C, 1'b0, 0, ac, e, rd, pf, pl);
    force_en = 1'b0;
    chk("vfy_ack_cycle", ac, VER ? 16 : 12);
    chk("vfy_err", 32'(e), VER ? 1 : 0);
    chk("vfy_rdata", 32'(rd), VER ? 32'h38 : 32'hA5);

    // Back-to-back reads at both address extremes.
    run_op(1'b1, 7'h00, 8'h00, 1'b0, 0, ac, e, rd, pf, pl);
    chk("rd00_ack_cycle", ac, 5);
    chk("rd00_rdata", 32'(rd), 32'h00);
    run_op(1'b1, 7'h7F, 8'h00, 1'b0, 0, ac, e, rd, pf, pl);
    chk("rd7f_ack_cycle", ac, 5);
    chk("rd7f_rdata", 32'(rd), 32'h3C);

    // req held high through a whole program op.
    run_op(1'b0, 7'h11, 8'h5A, 1'b0, 1, ac, e, rd, pf, pl);
    chk("spam_ack_cycle", ac, VER ? 16 : 12);
    chk("spam_idle_busy", 32'(hif.busy), 0);
    run_op(1'b1, 7'h11, 8'h00, 1'b0, 0, ac, e, rd, pf, pl);
    chk("spam_next_ack_cycle", ac, 5);
    chk("spam_next_rdata", 32'(rd), 32'h5A);

    // Randomised traffic with random ignored requests while busy.
    for (int i = 0; i < 60; i++)
      run_op(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'b0, 2, ac, e, rd, pf, pl);

    // Lock, then a protected program and a read.
    hif.lock_req = 1'b1;
    @(negedge clk); #1 hif.lock_req = 1'b0;
    chk("lock_wrong", 32'(otp_wrong), 1);
    run_op(1'b0, 7'h10, 8'h55, 1'b0, 0, ac, e, rd, pf, pl);
    chk("lock_no_pclk", pf, -1);
    chk("lock_prog_err", 32'(e), 1);
    run_op(1'b1, 7'h10, 8'h00, 1'b0, 0, ac, e, rd, pf, pl);
    chk("lock_read_rdata", 32'(rd), 32'hFF);
    chk("lock_read_err", 32'(e), 0);
    reset_pulse();
    chk("lock_cleared", 32'(otp_wrong), 0);

    // Lock pulse on the same edge as the accept.
    run_op(1'b0, 7'h20, 8'h66, 1'b1, 0, ac, e, rd, pf, pl);
    chk("colock_no_pclk", pf, -1);
    chk("colock_err", 32'(e), 1);
    reset_pulse();

    // Reset during the fifth pclk cycle.
    hif.req = 1'b1; hif.op = 1'b0; hif.host_addr = 7'h22; hif.host_wdata = 8'h77;
    @(posedge clk); #1 hif.req = 1'b0;
    repeat (7) @(negedge clk);
    chk("midprog_pclk_high", 32'(otp_pclk), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midprog_pclk_drop", 32'(otp_pclk), 0);
    chk("midprog_cs_drop", 32'(otp_cs_en), 0);
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("midprog_busy_after", 32'(hif.busy), 0);
    chk("midprog_lock_after", 32'(otp_wrong), 0);
    #1;
    run_op(1'b1, 7'h22, 8'h00, 1'b0, 0, ac, e, rd, pf, pl);
    chk("after_reset_read", 32'(rd), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected end within 2 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
